// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult
//   Iterative radix-2 shift-add multiplier with an unsigned and a
//   two's-complement signed mode. Each accepted request takes WIDTH cycles
//   in CALC. The result is then published in DONE together with a one-cycle
//   done pulse. A new request may be accepted in DONE, which gives
//   back-to-back operation.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   req   request; a, b and sgn are captured when req && rdy at a clock edge
//   rdy   high in IDLE and DONE (block can accept)
//   a     multiplicand, WIDTH bits
//   b     multiplier, WIDTH bits
//   sgn   1 = signed operands, 0 = unsigned
//   done  single-cycle pulse, ab holds a fresh product
//   ab    product, 2*WIDTH bits; holds until the next DONE
// ---------------------------------------------------------------------------
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic                 rdy,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 done,
  output logic [2*WIDTH-1:0]   ab
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] add_term;
  logic [2*WIDTH-1:0] acc_sum;

  // Operand conditioning and the shift-add datapath step.
  // In signed mode the operands are reduced to magnitudes, and the sign is
  // re-applied to the finished product. The magnitude of -2^(WIDTH-1) is
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits. This is why the
  // most-negative squared case comes out exact.
  // acc_sum is the accumulator after the current multiplier bit. On the last
  // CALC cycle it is the complete magnitude product, so it is used directly
  // to form ab without spending an extra cycle.
  always_comb begin
    a_neg    = sgn & a[WIDTH-1];
    b_neg    = sgn & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    add_term = mplier[0] ? mcand : '0;
    acc_sum  = acc + add_term;
  end

  // Control FSM and datapath registers.
  // rdy and done are registered together with the state, so they change
  // exactly on state entry.
  // A request offered while in CALC is not looked at, so there is no
  // queueing. Reset wins over everything and discards any operation in
  // flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      done   <= 1'b0;
      ab     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (req && rdy) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
            rdy    <= 1'b0;
          end else begin
            state  <= IDLE;
            rdy    <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            ab    <= neg ? -acc_sum : acc_sum;
            done  <= 1'b1;
            rdy   <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult
//   Directed and randomized checks of seq_mult at WIDTH = 8. Expected
//   products come from a plain-arithmetic model of signed/unsigned
//   multiplication. Timing expectations come from the required latency of
//   WIDTH CALC cycles followed by one DONE cycle.
// ---------------------------------------------------------------------------
module tb_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           req;
  logic           rdy;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           done;
  logic [2*W-1:0] ab;

  int checks;
  int errors;
  logic [2*W-1:0] last_ab;

  seq_mult #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .rdy  (rdy),
    .a    (a),
    .b    (b),
    .sgn  (sgn),
    .done (done),
    .ab   (ab)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: interpret operands as integers and multiply.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
    longint px;
    longint py;
    logic [63:0] r;
    px = longint'(x);
    py = longint'(y);
    if (s && x[W-1]) px = px - (longint'(1) << W);
    if (s && y[W-1]) py = py - (longint'(1) << W);
    r = 64'(px * py);
    return r[2*W-1:0];
  endfunction

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic s);
    req = r;
    a   = x;
    b   = y;
    sgn = s;
  endtask

  // One complete operation. This task checks the latency, that rdy stays low
  // in CALC and that ab holds its value until DONE. It then checks the
  // product and that done lasts one cycle. If perturb is set, the operands
  // are scrambled and req is pulsed during CALC.
  task automatic runOp(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic s, input bit perturb);
    int n;
    int lat;
    int rdy_bad;
    int hold_bad;
    logic [2*W-1:0] exp_ab;
    n = 0;
    while (!rdy && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rdy_wait"}, 32'(rdy), 32'd1);
    exp_ab = model(x, y, s);
    applyStimulus(1'b1, x, y, s);
    tick();
    req = 1'b0;
    lat = 0;
    rdy_bad = 0;
    hold_bad = 0;
    for (int c = 1; c <= W + 5; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (rdy) rdy_bad++;
      if (ab !== last_ab) hold_bad++;
      if (perturb && c == 2)
        applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      if (perturb && c == 3) req = 1'b0;
      tick();
    end
    req = 1'b0;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(W + 1));
    checkOutput({tag, "_rdy_calc"}, 32'(rdy_bad), 32'd0);
    checkOutput({tag, "_ab_hold"}, 32'(hold_bad), 32'd0);
    checkOutput({tag, "_ab"}, 32'(ab), 32'(exp_ab));
    checkOutput({tag, "_rdy_done"}, 32'(rdy), 32'd1);
    last_ab = exp_ab;
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int first;
    int second;
    int bad;
    int cnt_done;
    logic [2*W-1:0] ab1;
    logic [2*W-1:0] ab2;

    checks  = 0;
    errors  = 0;
    last_ab = '0;
    rst     = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);

    // Reset state
    tick(); tick(); tick();
    checkOutput("reset_rdy", 32'(rdy), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ab", 32'(ab), 32'd0);

    // First accept on the first edge with rst low
    rst = 1'b0;
    runOp("umax", 8'hFF, 8'hFF, 1'b0, 1'b0);
    checkOutput("umax_const", 32'(ab), 32'h0000FE01);
    runOp("sneg", 8'hFD, 8'h05, 1'b1, 1'b0);
    checkOutput("sneg_const", 32'(ab), 32'h0000FFF1);
    runOp("smin_sq", 8'h80, 8'h80, 1'b1, 1'b0);
    checkOutput("smin_sq_const", 32'(ab), 32'h00004000);
    runOp("mode_u", 8'h80, 8'hFF, 1'b0, 1'b0);
    checkOutput("mode_u_const", 32'(ab), 32'h00007F80);
    runOp("zero_u", 8'h00, 8'hA5, 1'b0, 1'b0);
    runOp("zero_s", 8'h9C, 8'h00, 1'b1, 1'b0);
    runOp("mode_s", 8'h80, 8'hFF, 1'b1, 1'b0);
    checkOutput("mode_s_const", 32'(ab), 32'h00000080);

    // Ignored request and operand change during CALC
    runOp("midchg", 8'h5A, 8'hC3, 1'b1, 1'b1);

    // Back-to-back with req held high
    applyStimulus(1'b1, 8'd3, 8'd4, 1'b0);
    tick();
    a = 8'h00;
    b = 8'h7F;
    first = 0;
    second = 0;
    bad = 0;
    ab1 = '0;
    ab2 = '0;
    for (int c = 1; c <= 2 * W + 4; c++) begin
      if (done) begin
        if (first == 0) begin
          first = c;
          ab1 = ab;
        end else if (second == 0) begin
          second = c;
          ab2 = ab;
          req = 1'b0;
        end
      end else if (rdy) begin
        bad++;
      end
      if (second != 0) break;
      tick();
    end
    req = 1'b0;
    checkOutput("b2b_first_cycle", 32'(first), 32'(W + 1));
    checkOutput("b2b_second_cycle", 32'(second), 32'(2 * (W + 1)));
    checkOutput("b2b_ab1", 32'(ab1), 32'(model(8'd3, 8'd4, 1'b0)));
    checkOutput("b2b_ab2", 32'(ab2), 32'(model(8'h00, 8'h7F, 1'b0)));
    checkOutput("b2b_rdy_calc", 32'(bad), 32'd0);
    tick();
    checkOutput("b2b_idle_done", 32'(done), 32'd0);
    last_ab = model(8'h00, 8'h7F, 1'b0);

    // Reset in CALC cycle 4 aborts the operation
    runOp("pre_rst", 8'd5, 8'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 8'h0D, 1'b0);
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_rdy", 32'(rdy), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_ab", 32'(ab), 32'd0);
    cnt_done = 0;
    for (int c = 0; c < 2 * W; c++) begin
      if (done) cnt_done++;
      tick();
    end
    checkOutput("abort_no_done", 32'(cnt_done), 32'd0);
    last_ab = '0;

    // Randomized operations with mid-operation disturbance
    for (int i = 0; i < 30; i++) begin
      runOp("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
